// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory sequencer: default sizes, FSM state encoding,
// grant source encoding and the address range check.
package cpu_pkg;

   localparam int WORD_SIZE_DEF   = 16;
   localparam int MEMORY_SIZE_DEF = 50;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      SRC_FETCH = 1'b0,
      SRC_DATA  = 1'b1
   } src_e;

   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned mem_size);
      return (addr < mem_size);
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/ack handshakes plus the memory port of the sequencer.
// slave = the sequencer itself, master = the core and memory around it.
interface mem_access_ctrl_if #(
   parameter int WORD_SIZE = 16
);
   logic                 i_req;
   logic [WORD_SIZE-1:0] i_addr;
   logic                 i_ack;
   logic [WORD_SIZE-1:0] i_rdata;
   logic                 d_req;
   logic                 d_we;
   logic [WORD_SIZE-1:0] d_addr;
   logic [WORD_SIZE-1:0] d_wdata;
   logic                 d_ack;
   logic [WORD_SIZE-1:0] d_rdata;
   logic                 err;
   logic                 busy;
   logic [WORD_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic                 mem_write;
   logic [WORD_SIZE-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, err, busy, mem_addr, mem_wdata, mem_write
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, err, busy, mem_addr, mem_wdata, mem_write
   );
endinterface

// File: rtl/mem_arb2.sv
// Two-requester arbiter: data has priority unless it won the previous grant,
// so a continuously requesting fetch port is never starved.
module mem_arb2
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_req,
   input  logic d_req,
   input  logic grant_en,
   output src_e gnt_src
);

   src_e last_q;
   src_e last_d;

   // Winner selection and last-grant bookkeeping
   always_comb begin
      if (d_req && (!i_req || (last_q == SRC_FETCH))) begin
         gnt_src = SRC_DATA;
      end else begin
         gnt_src = SRC_FETCH;
      end
      if (grant_en) begin
         last_d = gnt_src;
      end else begin
         last_d = last_q;
      end
   end

   // Last-grant register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= SRC_FETCH;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between core fetch/data ports and the unified memory: arbitrates,
// latches the granted transaction, inserts wait states and returns ack pulses.
module mem_access_ctrl
   import cpu_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEF,
   parameter int MEMORY_SIZE = MEMORY_SIZE_DEF,
   parameter int WAIT_CYCLES = 0
) (
   input  logic               clk,
   input  logic               reset,
   mem_access_ctrl_if.slave   bus
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e               state_q,     state_d;
   logic [3:0]           cnt_q,       cnt_d;
   src_e                 src_q,       src_d;
   logic                 we_q,        we_d;
   logic [WORD_SIZE-1:0] mem_addr_q,  mem_addr_d;
   logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
   logic [WORD_SIZE-1:0] i_rdata_q,   i_rdata_d;
   logic [WORD_SIZE-1:0] d_rdata_q,   d_rdata_d;
   logic                 i_ack_q,     i_ack_d;
   logic                 d_ack_q,     d_ack_d;
   logic                 err_q,       err_d;
   logic                 busy_q,      busy_d;

   logic                 grant_en_s;
   src_e                 gnt_src_s;
   logic                 in_range_s;
   logic [WORD_SIZE-1:0] rdata_s;

   mem_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_req    (bus.i_req),
      .d_req    (bus.d_req),
      .grant_en (grant_en_s),
      .gnt_src  (gnt_src_s)
   );

   assign in_range_s = addr_in_range(32'(mem_addr_q), MEMORY_SIZE);

   // Write strobe is combinational so it falls the instant reset leaves ACCESS
   assign bus.mem_write = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && we_q && in_range_s;

   // Next-state logic for the grant / wait / respond sequence
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      src_d       = src_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      err_d       = 1'b0;
      grant_en_s  = 1'b0;
      rdata_s     = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               grant_en_s = 1'b1;
               src_d      = gnt_src_s;
               cnt_d      = WAIT_INIT;
               state_d    = ST_ACCESS;
               if (gnt_src_s == SRC_DATA) begin
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
                  we_d        = bus.d_we;
               end else begin
                  mem_addr_d  = bus.i_addr;
                  mem_wdata_d = '0;
                  we_d        = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Stores and out-of-range loads return zero rather than memory data
               if (in_range_s && !we_q) begin
                  rdata_s = bus.mem_rdata;
               end else begin
                  rdata_s = '0;
               end
               if (src_q == SRC_DATA) begin
                  d_rdata_d = rdata_s;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = rdata_s;
                  i_ack_d   = 1'b1;
               end
               err_d   = !in_range_s;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         src_q       <= SRC_FETCH;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         src_q       <= src_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.i_ack     = i_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (0, 2 and 3 wait states) sharing one
// reset, each with its own memory, checked against a transaction-level model.
module tb_mem_access_ctrl;

   localparam int MSIZE = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  i_req_a, d_req_a, d_we_a;
   logic [15:0] i_addr_a [3];
   logic [15:0] d_addr_a [3];
   logic [15:0] d_wdata_a [3];
   logic [2:0]  i_ack_a, d_ack_a, err_a, busy_a, mem_write_a;
   logic [15:0] i_rdata_a [3];
   logic [15:0] d_rdata_a [3];
   logic [15:0] mem_addr_a [3];
   logic [15:0] mem_wdata_a [3];
   logic [15:0] mem_a [3][64];

   logic        pl_en;
   int          pl_k;
   logic [5:0]  pl_a;
   logic [15:0] pl_d;

   logic [15:0] ref_mem [3][64];
   bit          ref_last [3];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      mem_access_ctrl_if #(.WORD_SIZE(16)) bus ();
      assign bus.i_req     = i_req_a[k];
      assign bus.i_addr    = i_addr_a[k];
      assign bus.d_req     = d_req_a[k];
      assign bus.d_we      = d_we_a[k];
      assign bus.d_addr    = d_addr_a[k];
      assign bus.d_wdata   = d_wdata_a[k];
      assign bus.mem_rdata = mem_a[k][bus.mem_addr[5:0]];
      assign i_ack_a[k]     = bus.i_ack;
      assign d_ack_a[k]     = bus.d_ack;
      assign err_a[k]       = bus.err;
      assign busy_a[k]      = bus.busy;
      assign mem_write_a[k] = bus.mem_write;
      assign i_rdata_a[k]   = bus.i_rdata;
      assign d_rdata_a[k]   = bus.d_rdata;
      assign mem_addr_a[k]  = bus.mem_addr;
      assign mem_wdata_a[k] = bus.mem_wdata;
      mem_access_ctrl #(
         .WORD_SIZE   (16),
         .MEMORY_SIZE (MSIZE),
         .WAIT_CYCLES ((k == 0) ? 0 : ((k == 1) ? 2 : 3))
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus.slave)
      );
   end

   // Memory arrays: bench preload port plus each DUT's write port
   always @(posedge clk) begin
      if (pl_en) mem_a[pl_k][pl_a] <= pl_d;
      for (int k = 0; k < 3; k++) begin
         if (mem_write_a[k]) mem_a[k][mem_addr_a[k][5:0]] <= mem_wdata_a[k];
      end
   end

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
   endfunction

   task automatic preload(input int k, input int a, input logic [15:0] d);
      pl_en = 1'b1; pl_k = k; pl_a = 6'(a); pl_d = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
      ref_mem[k][a] = d;
   endtask

   // One transaction on a single port; the model derives latency, data, err and writes.
   task automatic do_txn(input int k, input bit is_d, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit drop, input string name);
      int          cyc = 0;
      int          wr = 0;
      bit          got = 1'b0;
      bit          both = 1'b0;
      bit          in_r;
      bit          w;
      logic [15:0] exp_rd;
      logic [15:0] got_rd;
      w      = is_d && we;
      in_r   = (addr < 16'(MSIZE));
      exp_rd = (!w && in_r) ? ref_mem[k][addr[5:0]] : 16'h0000;
      if (is_d) begin
         d_req_a[k] = 1'b1; d_we_a[k] = we; d_addr_a[k] = addr; d_wdata_a[k] = wdata;
      end else begin
         i_req_a[k] = 1'b1; i_addr_a[k] = addr;
      end
      while (!got && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (drop && cyc == 1) begin
            i_req_a[k] = 1'b0; d_req_a[k] = 1'b0; d_we_a[k] = ~d_we_a[k];
            i_addr_a[k] = 16'($urandom); d_addr_a[k] = 16'($urandom); d_wdata_a[k] = 16'($urandom);
         end
         wr += int'(mem_write_a[k]);
         if (i_ack_a[k] && d_ack_a[k]) both = 1'b1;
         if (is_d ? d_ack_a[k] : i_ack_a[k]) got = 1'b1;
      end
      i_req_a[k] = 1'b0; d_req_a[k] = 1'b0;
      if (w && in_r) ref_mem[k][addr[5:0]] = wdata;
      ref_last[k] = is_d;
      got_rd = is_d ? d_rdata_a[k] : i_rdata_a[k];
      checks++;
      if (!got) begin failures++; $display("FAIL %s ack_timeout cycles=%0d", name, cyc); end
      checks++;
      if (cyc !== wait_of(k) + 2) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, cyc, wait_of(k) + 2); end
      checks++;
      if (got_rd !== exp_rd) begin failures++; $display("FAIL %s rdata got=%h exp=%h", name, got_rd, exp_rd); end
      checks++;
      if (err_a[k] !== !in_r) begin failures++; $display("FAIL %s err got=%b exp=%b", name, err_a[k], !in_r); end
      checks++;
      if ((is_d ? i_ack_a[k] : d_ack_a[k]) !== 1'b0 || both) begin failures++; $display("FAIL %s wrong_ack i=%b d=%b", name, i_ack_a[k], d_ack_a[k]); end
      checks++;
      if (wr !== int'(w && in_r)) begin failures++; $display("FAIL %s write_count got=%0d exp=%0d", name, wr, int'(w && in_r)); end
      @(posedge clk); #1;
      got_rd = is_d ? d_rdata_a[k] : i_rdata_a[k];
      checks++;
      if ({busy_a[k], i_ack_a[k], d_ack_a[k], err_a[k]} !== 4'b0000 || got_rd !== exp_rd) begin
         failures++;
         $display("FAIL %s after_ack busy=%b i_ack=%b d_ack=%b err=%b rdata=%h exp_rdata=%h",
                  name, busy_a[k], i_ack_a[k], d_ack_a[k], err_a[k], got_rd, exp_rd);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pl_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_req_a[k] = 1'b0; d_req_a[k] = 1'b0; d_we_a[k] = 1'b0;
         i_addr_a[k] = 16'h0; d_addr_a[k] = 16'h0; d_wdata_a[k] = 16'h0;
         ref_last[k] = 1'b0;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         for (int a = 0; a < 64; a++) preload(k, a, 16'($urandom));
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({i_ack_a[k], d_ack_a[k], err_a[k], busy_a[k], mem_write_a[k]} !== 5'b00000 ||
             i_rdata_a[k] !== 16'h0 || d_rdata_a[k] !== 16'h0 ||
             mem_addr_a[k] !== 16'h0 || mem_wdata_a[k] !== 16'h0) begin
            failures++;
            $display("FAIL reset_state inst=%0d flags=%b i_rdata=%h d_rdata=%h addr=%h wdata=%h exp=all_zero", k,
                     {i_ack_a[k], d_ack_a[k], err_a[k], busy_a[k], mem_write_a[k]},
                     i_rdata_a[k], d_rdata_a[k], mem_addr_a[k], mem_wdata_a[k]);
         end
      end
      @(negedge clk); reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (busy_a[k] !== 1'b0) begin failures++; $display("FAIL idle_busy inst=%0d got=%b exp=0", k, busy_a[k]); end
      end
   endtask

   task automatic test_fetch_basic();
      preload(0, 5, 16'h1234);
      do_txn(0, 1'b0, 1'b0, 16'd5, 16'h0, 1'b0, "fetch_w0");
   endtask

   task automatic test_store_load();
      do_txn(1, 1'b1, 1'b1, 16'd10, 16'hBEEF, 1'b0, "store_w2");
      do_txn(1, 1'b1, 1'b0, 16'd10, 16'h0, 1'b0, "load_w2");
      checks++;
      if (d_rdata_a[1] !== 16'hBEEF) begin failures++; $display("FAIL load_beef got=%h exp=beef", d_rdata_a[1]); end
   endtask

   // Both ports held: winners follow the alternating-priority rule
   task automatic test_back_to_back();
      int          acks = 0;
      int          cyc = 0;
      bit          prev_src;
      bit          exp_src;
      logic [15:0] ai, ad;
      ai = 16'($urandom_range(0, MSIZE - 1));
      ad = 16'($urandom_range(0, MSIZE - 1));
      i_req_a[0] = 1'b1; i_addr_a[0] = ai;
      d_req_a[0] = 1'b1; d_we_a[0] = 1'b0; d_addr_a[0] = ad;
      prev_src = ref_last[0];
      while (acks < 4 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (i_ack_a[0] || d_ack_a[0]) begin
            exp_src = ref_last[0] ? 1'b0 : 1'b1;
            checks++;
            if (d_ack_a[0] !== exp_src || i_ack_a[0] !== !exp_src) begin
               failures++;
               $display("FAIL arb_order ack=%0d i_ack=%b d_ack=%b exp_data=%b", acks, i_ack_a[0], d_ack_a[0], exp_src);
            end
            checks++;
            if ((exp_src ? d_rdata_a[0] : i_rdata_a[0]) !== ref_mem[0][exp_src ? ad[5:0] : ai[5:0]]) begin
               failures++;
               $display("FAIL arb_rdata ack=%0d got=%h exp=%h", acks,
                        exp_src ? d_rdata_a[0] : i_rdata_a[0], ref_mem[0][exp_src ? ad[5:0] : ai[5:0]]);
            end
            if (acks > 0) begin
               checks++;
               if (d_ack_a[0] === prev_src) begin failures++; $display("FAIL arb_repeat ack=%0d src_data=%b prev=%b", acks, d_ack_a[0], prev_src); end
            end
            prev_src = d_ack_a[0];
            ref_last[0] = exp_src;
            acks++;
         end
      end
      i_req_a[0] = 1'b0; d_req_a[0] = 1'b0;
      checks++;
      if (acks !== 4) begin failures++; $display("FAIL arb_count got=%0d exp=4", acks); end
      @(posedge clk); #1;
   endtask

   task automatic test_out_of_range();
      do_txn(1, 1'b1, 1'b1, 16'd50, 16'h5A5A, 1'b0, "store_oor50");
      do_txn(1, 1'b1, 1'b0, 16'hFFFF, 16'h0, 1'b0, "load_oorFFFF");
      do_txn(1, 1'b1, 1'b0, 16'd49, 16'h0, 1'b0, "load_49");
   endtask

   task automatic test_reset_mid_access();
      int          acks = 0;
      logic [15:0] old;
      old = ref_mem[2][20];
      d_req_a[2] = 1'b1; d_we_a[2] = 1'b1; d_addr_a[2] = 16'd20; d_wdata_a[2] = ~old;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (mem_write_a[2] !== 1'b1 || busy_a[2] !== 1'b1) begin
         failures++; $display("FAIL pre_reset write=%b busy=%b exp=1,1", mem_write_a[2], busy_a[2]);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (mem_write_a[2] !== 1'b0 || busy_a[2] !== 1'b0) begin
         failures++; $display("FAIL async_reset write=%b busy=%b exp=0,0", mem_write_a[2], busy_a[2]);
      end
      d_req_a[2] = 1'b0;
      for (int k = 0; k < 3; k++) ref_last[k] = 1'b0;
      @(negedge clk); reset = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         acks += int'(d_ack_a[2]);
      end
      checks++;
      if (acks !== 0) begin failures++; $display("FAIL lost_txn_ack got=%0d exp=0", acks); end
      checks++;
      if (mem_a[2][20] !== old) begin failures++; $display("FAIL lost_txn_mem got=%h exp=%h", mem_a[2][20], old); end
      do_txn(2, 1'b1, 1'b0, 16'd20, 16'h0, 1'b0, "load_after_reset");
   endtask

   task automatic test_drop_req();
      do_txn(2, 1'b1, 1'b0, 16'd7, 16'h0, 1'b1, "drop_load");
      do_txn(2, 1'b1, 1'b1, 16'd8, 16'hC0DE, 1'b1, "drop_store");
      do_txn(2, 1'b0, 1'b0, 16'd8, 16'h0, 1'b1, "drop_fetch");
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         int          k;
         logic [15:0] a;
         k = $urandom_range(0, 2);
         a = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, MSIZE - 1)) : 16'($urandom_range(MSIZE, 65535));
         do_txn(k, 1'($urandom), 1'($urandom), a, 16'($urandom), ($urandom_range(0, 4) == 0), "random");
      end
   endtask

   task automatic test_memory_final();
      for (int k = 0; k < 3; k++) begin
         int bad = 0;
         for (int a = 0; a < 64; a++) if (mem_a[k][a] !== ref_mem[k][a]) bad++;
         checks++;
         if (bad != 0) begin failures++; $display("FAIL memory_image inst=%0d mismatched_words=%0d exp=0", k, bad); end
      end
   endtask

   initial begin
      test_reset();
      test_fetch_basic();
      test_store_load();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_access();
      test_drop_req();
      test_random();
      test_memory_final();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer between the CPU core and the unified instruction/data memory. Accepts instruction-fetch and data load/store requests from the core and arbitrates between them. Drives the memory's addr/data_in/write port and captures its combinational data_out. Models programmable wait states, rejects out-of-range addresses, and returns one-cycle ack pulses with held read data.

Parameters:
WORD_SIZE, 16, width of data and address words
MEMORY_SIZE, 50, number of valid words; addresses >= MEMORY_SIZE are out of range
WAIT_CYCLES, 0, extra memory access cycles per transaction (0..15)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  WORD_SIZE  fetch address
i_ack  out  1  one-cycle pulse, fetch complete
i_rdata  out  WORD_SIZE  fetched word, valid at i_ack, held until next i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  WORD_SIZE  data address
d_wdata  in  WORD_SIZE  store data
d_ack  out  1  one-cycle pulse, data access complete
d_rdata  out  WORD_SIZE  load result, valid at d_ack, held until next d_ack
err  out  1  pulses with the ack when the granted address was out of range
busy  out  1  high whenever state != IDLE
mem_addr  out  WORD_SIZE  to memory addr
mem_wdata  out  WORD_SIZE  to memory data_in
mem_write  out  1  to memory write
mem_rdata  in  WORD_SIZE  from memory data_out (combinational read)

Behaviour:
- Reset (async, immediate): state IDLE; mem_addr, mem_wdata, i_rdata, d_rdata = 0; mem_write, i_ack, d_ack, err, busy = 0; cnt = 0; last_grant = fetch.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is pending, grant it and latch addr, we, wdata and source into mem_addr/mem_wdata/internal regs. Set cnt = WAIT_CYCLES and go to ACCESS. With no request, stay in IDLE.
- Arbitration when both requests are pending: data wins unless last_grant == data, in which case fetch wins (no starvation). A sole requester always wins. Update last_grant on each grant.
- ACCESS: if cnt != 0, decrement and stay. If cnt == 0:
  - capture mem_rdata into the granted source's rdata reg, or 0 if the address is out of range or the access is a store;
  - go to RESP.
- mem_write is combinational: state==ACCESS && cnt==0 && granted store && address in range. It is high for exactly one cycle per in-range store and never high outside ACCESS.
- RESP: pulse the granted source's ack for one cycle, pulse err if the address was out of range, then go to IDLE. The requester may drop req in the ack cycle.
- Latency: a request first seen at edge E is acked in the cycle after edge E+WAIT_CYCLES+1. Minimum is 2 cycles; throughput is 1 access per WAIT_CYCLES+3 cycles.
- Range check: unsigned addr < MEMORY_SIZE. An out-of-range store performs no write; an out-of-range load returns 0; err=1 in both cases.
- Req dropped before ack: the latched transaction still completes and acks. No cancellation.
- Input changes after grant are ignored because latched copies drive memory.
- Reset mid-ACCESS: mem_write drops immediately; no ack is issued; the transaction is lost.
- Only one ack is asserted per cycle; i_ack and d_ack are never high together.

Decomposition:
- Shared package cpu_pkg: WORD_SIZE and MEMORY_SIZE defaults, the state encoding (IDLE/ACCESS/RESP), and the grant source encoding (SRC_FETCH/SRC_DATA).
- One natural sub-module, mem_arb2: the two-requester arbiter with last_grant register, returning grant source. The wait counter and FSM stay in mem_access_ctrl.

Test Plan:
- WAIT=0, memory[5]=16'h1234, i_req with i_addr=5 -> i_ack 2 cycles after req, i_rdata=16'h1234, err=0, mem_write never high.
- WAIT=2, d_req store d_addr=10 d_wdata=16'hBEEF, then load addr 10 -> mem_write high exactly 1 cycle, d_ack 4 cycles after req, load returns 16'hBEEF.
- i_req and d_req held together continuously, 4 transactions -> grants alternate D,I,D,I; no consecutive same-source acks.
- Store to addr 50 with MEMORY_SIZE=50 -> mem_write stays 0, d_ack with err=1, memory[49] unchanged. Load from addr 16'hFFFF -> d_rdata=0, err=1.
- reset asserted mid-ACCESS of a store with WAIT=3 -> mem_write and busy drop asynchronously, no d_ack, target word unchanged; next request after release completes normally.
- d_req dropped one cycle after grant -> d_ack still pulses once, and the following idle cycle shows busy=0.
